// File: rtl/axi4_burst_master_pkg.sv
// ---------------------------------------------------------------------------
// axi4_burst_master_pkg
// Shared definitions for the AXI4 burst master slice:
//   - state_t      : transaction FSM states
//   - RESP_*       : AXI response codes (ordered by severity = numeric value)
//   - BOUNDARY_4K  : AXI bursts must not cross a 4 KB address boundary
//   - OFFSET_BITS  : number of address bits that index inside a 4 KB page
//   - resp_max()   : response merge (keeps the numerically largest code)
// ---------------------------------------------------------------------------
package axi4_burst_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_ADDR,
    W_DATA,
    W_RESP,
    R_ADDR,
    R_DATA,
    DONE
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int BOUNDARY_4K = 4096;
  localparam int OFFSET_BITS = 12;

  // OKAY < EXOKAY < SLVERR < DECERR, so the worst response is the max value.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi4_burst_master_if.sv
// ---------------------------------------------------------------------------
// axi4_burst_master_if
// Bundles every non-clock/reset signal of the burst master:
//   - command side : cmd_valid/cmd_ready, cmd_write, cmd_addr, cmd_len, cmd_size
//   - write stream : wd_valid/wd_ready, wd_data
//   - read stream  : rd_valid/rd_ready, rd_data, rd_last
//   - completion   : done, done_resp, done_err
//   - AXI4 AW/W/B/AR/R channels (INCR bursts only)
// Modports:
//   master : the burst master block itself
//   slave  : the environment (user logic + AXI slave) around the block
// ---------------------------------------------------------------------------
interface axi4_burst_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);

  // command
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [7:0]            cmd_len;
  logic [2:0]            cmd_size;
  // user write-data stream
  logic                  wd_valid;
  logic                  wd_ready;
  logic [DATA_WIDTH-1:0] wd_data;
  // user read-data stream
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;
  // completion
  logic                  done;
  logic [1:0]            done_resp;
  logic                  done_err;
  // AXI write address
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [7:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic                  AWVALID;
  logic                  AWREADY;
  // AXI write data
  logic [DATA_WIDTH-1:0] WDATA;
  logic                  WLAST;
  logic                  WVALID;
  logic                  WREADY;
  // AXI write response
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;
  // AXI read address
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [7:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic                  ARVALID;
  logic                  ARREADY;
  // AXI read data
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_size,
    output cmd_ready,
    input  wd_valid, wd_data,
    output wd_ready,
    input  rd_ready,
    output rd_valid, rd_data, rd_last,
    output done, done_resp, done_err,
    output AWADDR, AWLEN, AWSIZE, AWVALID,
    input  AWREADY,
    output WDATA, WLAST, WVALID,
    input  WREADY,
    input  BRESP, BVALID,
    output BREADY,
    output ARADDR, ARLEN, ARSIZE, ARVALID,
    input  ARREADY,
    input  RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_size,
    input  cmd_ready,
    output wd_valid, wd_data,
    input  wd_ready,
    output rd_ready,
    input  rd_valid, rd_data, rd_last,
    input  done, done_resp, done_err,
    input  AWADDR, AWLEN, AWSIZE, AWVALID,
    output AWREADY,
    input  WDATA, WLAST, WVALID,
    output WREADY,
    output BRESP, BVALID,
    input  BREADY,
    input  ARADDR, ARLEN, ARSIZE, ARVALID,
    output ARREADY,
    output RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

endinterface

// File: rtl/axi4_cmd_check.sv
// ---------------------------------------------------------------------------
// axi4_cmd_check
// Purely combinational legality check of a burst command.
// Ports:
//   addr_offset in  OFFSET_BITS  start address within its 4 KB page
//   len         in  8            beats minus one
//   size        in  3            log2(bytes per beat)
//   cmd_ok      out 1            1 = burst may be issued on AXI
// A command is legal when the beat size fits the data bus, the start
// address is aligned to the beat size, and the burst ends at or before the
// next 4 KB boundary.
// ---------------------------------------------------------------------------
module axi4_cmd_check
  import axi4_burst_master_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [OFFSET_BITS-1:0] addr_offset,
  input  logic [7:0]             len,
  input  logic [2:0]             size,
  output logic                   cmd_ok
);

  localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

  logic        size_ok;
  logic        aligned;
  logic        in_page;
  logic [16:0] span;        // (len+1) << size, at most 256 << 7
  logic [17:0] end_offset;  // one past the last byte, relative to the page
  logic [6:0]  align_mask;

  always_comb begin
    span       = (17'(len) + 17'd1) << size;
    end_offset = 18'(addr_offset) + 18'(span);
    align_mask = 7'((8'd1 << size) - 8'd1);
    size_ok    = (int'(size) <= MAX_SIZE);
    aligned    = (addr_offset[6:0] & align_mask) == 7'd0;
    // Ending exactly on the boundary is fine; only a byte past it crosses.
    in_page    = end_offset <= 18'(BOUNDARY_4K);
    cmd_ok     = size_ok && aligned && in_page;
  end

endmodule

// File: rtl/axi4_burst_master.sv
// ---------------------------------------------------------------------------
// axi4_burst_master
// Turns one user command at a time into a single AXI4 INCR burst.
// Ports:
//   ACLK    in  clock, rising edge
//   ARESET  in  synchronous active-high reset; aborts any transaction
//   bus     axi4_burst_master_if.master: command, user write/read streams,
//           completion (done/done_resp/done_err) and the AXI AW/W/B/AR/R
//           channels
// Illegal commands (size too large, misaligned, crossing 4 KB) produce no
// AXI traffic and complete immediately with done_err=1, done_resp=SLVERR.
// Write/read data are passed combinationally between the user streams and
// the AXI W/R channels while in the data phase.
// ---------------------------------------------------------------------------
module axi4_burst_master
  import axi4_burst_master_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                ACLK,
  input  logic                ARESET,
  axi4_burst_master_if.master bus
);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [7:0]            len_reg, len_next;
  logic [2:0]            size_reg, size_next;
  logic [7:0]            cnt_reg, cnt_next;
  logic [1:0]            resp_reg, resp_next;
  logic                  err_reg, err_next;
  logic                  cmd_ok;
  logic                  last_beat;

  axi4_cmd_check #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cmd_check (
    .addr_offset (bus.cmd_addr[OFFSET_BITS-1:0]),
    .len         (bus.cmd_len),
    .size        (bus.cmd_size),
    .cmd_ok      (cmd_ok)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      len_reg   <= '0;
      size_reg  <= '0;
      cnt_reg   <= '0;
      resp_reg  <= RESP_OKAY;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      len_reg   <= len_next;
      size_reg  <= size_next;
      cnt_reg   <= cnt_next;
      resp_reg  <= resp_next;
      err_reg   <= err_next;
    end
  end

  assign last_beat = (cnt_reg == len_reg);

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    len_next      = len_reg;
    size_next     = size_reg;
    cnt_next      = cnt_reg;
    resp_next     = resp_reg;
    err_next      = err_reg;

    bus.cmd_ready = 1'b0;
    bus.wd_ready  = 1'b0;
    bus.rd_valid  = 1'b0;
    bus.rd_data   = bus.RDATA;
    bus.rd_last   = 1'b0;
    bus.done      = 1'b0;
    bus.done_resp = RESP_OKAY;
    bus.done_err  = 1'b0;
    bus.AWADDR    = addr_reg;
    bus.AWLEN     = len_reg;
    bus.AWSIZE    = size_reg;
    bus.AWVALID   = 1'b0;
    bus.WDATA     = bus.wd_data;
    bus.WLAST     = 1'b0;
    bus.WVALID    = 1'b0;
    bus.BREADY    = 1'b0;
    bus.ARADDR    = addr_reg;
    bus.ARLEN     = len_reg;
    bus.ARSIZE    = size_reg;
    bus.ARVALID   = 1'b0;
    bus.RREADY    = 1'b0;

    case (state_reg)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          addr_next = bus.cmd_addr;
          len_next  = bus.cmd_len;
          size_next = bus.cmd_size;
          cnt_next  = '0;
          resp_next = RESP_OKAY;
          err_next  = 1'b0;
          if (!cmd_ok) begin
            resp_next  = RESP_SLVERR;
            err_next   = 1'b1;
            state_next = DONE;
          end else begin
            state_next = bus.cmd_write ? W_ADDR : R_ADDR;
          end
        end
      end

      W_ADDR: begin
        bus.AWVALID = 1'b1;
        if (bus.AWREADY) state_next = W_DATA;
      end

      W_DATA: begin
        bus.WVALID   = bus.wd_valid;
        bus.wd_ready = bus.WREADY;
        bus.WLAST    = last_beat;
        if (bus.wd_valid && bus.WREADY) begin
          cnt_next = cnt_reg + 8'd1;
          if (last_beat) state_next = W_RESP;
        end
      end

      W_RESP: begin
        bus.BREADY = 1'b1;
        if (bus.BVALID) begin
          resp_next  = resp_max(resp_reg, bus.BRESP);
          state_next = DONE;
        end
      end

      R_ADDR: begin
        bus.ARVALID = 1'b1;
        if (bus.ARREADY) state_next = R_DATA;
      end

      R_DATA: begin
        bus.RREADY   = bus.rd_ready;
        bus.rd_valid = bus.RVALID;
        bus.rd_last  = last_beat;
        if (bus.RVALID && bus.rd_ready) begin
          cnt_next  = cnt_reg + 8'd1;
          resp_next = resp_max(resp_reg, bus.RRESP);
          // The slave's RLAST must agree with our own beat count.
          if (bus.RLAST != last_beat) err_next = 1'b1;
          // Stop on whichever end marker arrives first so a short or long
          // burst from the slave can never wedge the FSM.
          if (bus.RLAST || last_beat) state_next = DONE;
        end
      end

      DONE: begin
        bus.done      = 1'b1;
        bus.done_resp = resp_reg;
        bus.done_err  = err_reg;
        state_next    = IDLE;
      end

      default: state_next = IDLE;
    endcase

    // Handshake and status outputs are forced low for the whole time reset
    // is held, not only from the cycle after it is sampled.
    if (ARESET) begin
      bus.cmd_ready = 1'b0;
      bus.wd_ready  = 1'b0;
      bus.rd_valid  = 1'b0;
      bus.rd_last   = 1'b0;
      bus.done      = 1'b0;
      bus.done_resp = RESP_OKAY;
      bus.done_err  = 1'b0;
      bus.AWVALID   = 1'b0;
      bus.WLAST     = 1'b0;
      bus.WVALID    = 1'b0;
      bus.BREADY    = 1'b0;
      bus.ARVALID   = 1'b0;
      bus.RREADY    = 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4_burst_master.sv
// ---------------------------------------------------------------------------
// tb_axi4_burst_master
// Directed bench for axi4_burst_master. A small procedural AXI slave and
// user-side driver run each transaction; expected values are hand-derived.
// ---------------------------------------------------------------------------
module tb_axi4_burst_master;
  import axi4_burst_master_pkg::*;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  axi4_burst_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

  axi4_burst_master #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (16)
  ) dut (
    .ACLK   (aclk),
    .ARESET (areset),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // slave behaviour knobs and per-transaction results
  logic [1:0] rresp_tbl [0:15];
  int         rlast_beat;
  logic       got_done;
  logic [1:0] got_resp;
  logic       got_err;
  int         n_w, n_r, n_ar, n_aw_cyc, n_wlast, done_cyc;
  logic       aw_unstable, w_before_aw;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.cmd_valid = 1'b0;
    bus.wd_valid  = 1'b0;
    bus.wd_data   = '0;
    bus.rd_ready  = 1'b0;
    bus.AWREADY   = 1'b0;
    bus.WREADY    = 1'b0;
    bus.BVALID    = 1'b0;
    bus.BRESP     = 2'b00;
    bus.ARREADY   = 1'b0;
    bus.RVALID    = 1'b0;
    bus.RDATA     = '0;
    bus.RRESP     = 2'b00;
    bus.RLAST     = 1'b0;
  endtask

  function automatic logic [13:0] outs();
    return {bus.cmd_ready, bus.wd_ready, bus.rd_valid, bus.rd_last, bus.done,
            bus.done_err, bus.done_resp, bus.AWVALID, bus.WVALID, bus.WLAST,
            bus.BREADY, bus.ARVALID, bus.RREADY};
  endfunction

  // Issue one command, then act as user + AXI slave until done (or until
  // stop_after_w write beats have been accepted, leaving the burst open).
  task automatic run_txn(input string name, input logic wr, input logic [15:0] addr,
                         input logic [7:0] len, input logic [2:0] size, input int aw_stall,
                         input logic rd_toggle, input logic [1:0] bresp, input int stop_after_w);
    logic        aw_done, ar_done, b_pend, aw_seen;
    logic [26:0] aw_first;
    int          aw_wait, r_idx, cyc;
    aw_done = 0; ar_done = 0; b_pend = 0; aw_seen = 0; aw_first = '0;
    aw_wait = 0; r_idx = 0; cyc = 0;
    got_done = 0; got_resp = 2'b00; got_err = 0;
    n_w = 0; n_r = 0; n_ar = 0; n_aw_cyc = 0; n_wlast = 0; done_cyc = -1;
    aw_unstable = 0; w_before_aw = 0;

    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    bus.cmd_size  = size;
    @(negedge aclk);
    chk({name, ".cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
    step();
    bus.cmd_valid = 1'b0;

    while (cyc < 300 && !got_done && !(stop_after_w > 0 && n_w == stop_after_w)) begin
      bus.AWREADY  = (aw_wait >= aw_stall);
      bus.WREADY   = 1'b1;
      bus.wd_valid = 1'b1;
      bus.wd_data  = 32'hA000_0000 + 32'(n_w);
      bus.BVALID   = b_pend;
      bus.BRESP    = bresp;
      bus.ARREADY  = 1'b1;
      bus.RVALID   = ar_done && (r_idx <= int'(len));
      bus.RDATA    = 32'hB000_0000 + 32'(r_idx);
      bus.RRESP    = rresp_tbl[r_idx[3:0]];
      bus.RLAST    = (r_idx == rlast_beat);
      bus.rd_ready = rd_toggle ? (cyc % 2 == 0) : 1'b1;
      @(negedge aclk);
      if (bus.AWVALID) begin
        n_aw_cyc++;
        if (!aw_seen) begin
          aw_seen  = 1;
          aw_first = {bus.AWADDR, bus.AWLEN, bus.AWSIZE};
        end else if ({bus.AWADDR, bus.AWLEN, bus.AWSIZE} != aw_first) begin
          aw_unstable = 1;
        end
        if (bus.AWREADY) begin
          aw_done = 1;
          chk({name, ".aw"}, 64'({bus.AWADDR, bus.AWLEN, bus.AWSIZE}), 64'({addr, len, size}));
        end else begin
          aw_wait++;
        end
      end
      if (bus.WVALID && !aw_done) w_before_aw = 1;
      if (bus.WVALID && bus.WREADY) begin
        chk({name, ".wdata"}, 64'(bus.WDATA), 64'(32'hA000_0000 + 32'(n_w)));
        chk({name, ".wlast"}, 64'(bus.WLAST), 64'(n_w == int'(len)));
        if (bus.WLAST) begin
          b_pend = 1;
          n_wlast++;
        end
        n_w++;
      end
      if (bus.BVALID && bus.BREADY) b_pend = 0;
      if (bus.ARVALID && bus.ARREADY) begin
        n_ar++;
        ar_done = 1;
        chk({name, ".ar"}, 64'({bus.ARADDR, bus.ARLEN, bus.ARSIZE}), 64'({addr, len, size}));
      end
      if (bus.rd_valid && bus.rd_ready) begin
        chk({name, ".rdata"}, 64'(bus.rd_data), 64'(32'hB000_0000 + 32'(n_r)));
        chk({name, ".rd_last"}, 64'(bus.rd_last), 64'(n_r == int'(len)));
        n_r++;
        r_idx++;
      end
      if (bus.done) begin
        got_done = 1;
        got_resp = bus.done_resp;
        got_err  = bus.done_err;
        done_cyc = cyc;
      end
      step();
      cyc++;
    end

    if (stop_after_w == 0) begin
      chk({name, ".done_seen"}, 64'(got_done), 64'd1);
      clear_inputs();
      @(negedge aclk);
      // done lasts one cycle and the block is back in IDLE
      chk({name, ".done_1cyc"}, 64'({bus.done, bus.cmd_ready}), 64'(2'b01));
      step();
    end
    $display("txn %0s wr=%0b addr=%h len=%0d size=%0d done=%0b resp=%0d err=%0b w=%0d r=%0d cyc=%0d",
             name, wr, addr, len, size, got_done, got_resp, got_err, n_w, n_r, done_cyc);
  endtask

  task automatic set_rresp(input logic [1:0] r0, input logic [1:0] r1,
                           input logic [1:0] r2, input logic [1:0] r3);
    for (int i = 0; i < 16; i++) rresp_tbl[i] = RESP_OKAY;
    rresp_tbl[0] = r0;
    rresp_tbl[1] = r1;
    rresp_tbl[2] = r2;
    rresp_tbl[3] = r3;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1;
    clear_inputs();
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.cmd_size  = '0;
    set_rresp(RESP_OKAY, RESP_OKAY, RESP_OKAY, RESP_OKAY);
    rlast_beat = 0;

    // reset: command offered while reset is held must see no ready
    bus.cmd_valid = 1'b1;
    step();
    step();
    @(negedge aclk);
    chk("rst.outs", 64'(outs()), 64'd0);
    step();
    bus.cmd_valid = 1'b0;
    areset = 1'b0;
    @(negedge aclk);
    chk("rst.idle", 64'(outs()), 64'(14'h2000));
    step();

    // 4-beat write, slave always ready
    run_txn("wr4", 1'b1, 16'h0010, 8'd3, 3'd2, 0, 1'b0, RESP_OKAY, 0);
    chk("wr4.resp", 64'(got_resp), 64'(RESP_OKAY));
    chk("wr4.err", 64'(got_err), 64'd0);
    chk("wr4.beats", 64'(n_w), 64'd4);
    chk("wr4.wlast_cnt", 64'(n_wlast), 64'd1);

    // single-beat write latency: handshake cycle through done cycle = 5
    run_txn("lat", 1'b1, 16'h0020, 8'd0, 3'd2, 0, 1'b0, RESP_OKAY, 0);
    chk("lat.cycles", 64'(done_cyc + 2), 64'd5);
    chk("lat.beats", 64'(n_w), 64'd1);

    // crosses 0x1000: rejected, no AXI traffic
    run_txn("rej4k", 1'b1, 16'h0FF8, 8'd3, 3'd2, 0, 1'b0, RESP_OKAY, 0);
    chk("rej4k.awvalid_cyc", 64'(n_aw_cyc), 64'd0);
    chk("rej4k.beats", 64'(n_w), 64'd0);
    chk("rej4k.resp", 64'(got_resp), 64'(RESP_SLVERR));
    chk("rej4k.err", 64'(got_err), 64'd1);

    // ends exactly on 0x1000: legal; DECERR response reported
    run_txn("edge4k", 1'b1, 16'h0FF0, 8'd3, 3'd2, 0, 1'b0, RESP_DECERR, 0);
    chk("edge4k.beats", 64'(n_w), 64'd4);
    chk("edge4k.resp", 64'(got_resp), 64'(RESP_DECERR));
    chk("edge4k.err", 64'(got_err), 64'd0);

    // misaligned read and oversize read: rejected
    run_txn("rej_align", 1'b0, 16'h0102, 8'd0, 3'd2, 0, 1'b0, RESP_OKAY, 0);
    chk("rej_align.ar", 64'(n_ar), 64'd0);
    chk("rej_align.flags", 64'({got_err, got_resp}), 64'(3'b110));
    run_txn("rej_size", 1'b0, 16'h0100, 8'd0, 3'd3, 0, 1'b0, RESP_OKAY, 0);
    chk("rej_size.ar", 64'(n_ar), 64'd0);
    chk("rej_size.flags", 64'({got_err, got_resp}), 64'(3'b110));

    // 8-beat read with rd_ready toggling
    set_rresp(RESP_OKAY, RESP_OKAY, RESP_OKAY, RESP_OKAY);
    rlast_beat = 7;
    run_txn("rd8", 1'b0, 16'h0100, 8'd7, 3'd2, 0, 1'b1, RESP_OKAY, 0);
    chk("rd8.beats", 64'(n_r), 64'd8);
    chk("rd8.ar", 64'(n_ar), 64'd1);
    chk("rd8.flags", 64'({got_err, got_resp}), 64'(3'b000));

    // RRESP 0,0,2,0 -> worst is SLVERR
    set_rresp(RESP_OKAY, RESP_OKAY, RESP_SLVERR, RESP_OKAY);
    rlast_beat = 3;
    run_txn("rd_resp", 1'b0, 16'h0200, 8'd3, 3'd2, 0, 1'b0, RESP_OKAY, 0);
    chk("rd_resp.beats", 64'(n_r), 64'd4);
    chk("rd_resp.resp", 64'(got_resp), 64'(RESP_SLVERR));
    chk("rd_resp.err", 64'(got_err), 64'd0);

    // RLAST on beat 2 of 4 -> error, leaves after beat 2
    set_rresp(RESP_OKAY, RESP_OKAY, RESP_OKAY, RESP_OKAY);
    rlast_beat = 1;
    run_txn("rd_early", 1'b0, 16'h0300, 8'd3, 3'd2, 0, 1'b0, RESP_OKAY, 0);
    chk("rd_early.beats", 64'(n_r), 64'd2);
    chk("rd_early.err", 64'(got_err), 64'd1);
    chk("rd_early.resp", 64'(got_resp), 64'(RESP_OKAY));

    // RLAST missing on the final beat -> error; EXOKAY merged
    set_rresp(RESP_EXOKAY, RESP_OKAY, RESP_OKAY, RESP_OKAY);
    rlast_beat = 99;
    run_txn("rd_nolast", 1'b0, 16'h0400, 8'd1, 3'd2, 0, 1'b0, RESP_OKAY, 0);
    chk("rd_nolast.beats", 64'(n_r), 64'd2);
    chk("rd_nolast.flags", 64'({got_err, got_resp}), 64'(3'b101));

    // AWREADY low for 10 cycles
    run_txn("aw_stall", 1'b1, 16'h0040, 8'd1, 3'd2, 10, 1'b0, RESP_OKAY, 0);
    chk("aw_stall.awvalid_cyc", 64'(n_aw_cyc), 64'd11);
    chk("aw_stall.stable", 64'(aw_unstable), 64'd0);
    chk("aw_stall.w_early", 64'(w_before_aw), 64'd0);
    chk("aw_stall.beats", 64'(n_w), 64'd2);

    // reset during W_DATA of an 8-beat write
    run_txn("w_abort", 1'b1, 16'h0500, 8'd7, 3'd2, 0, 1'b0, RESP_OKAY, 2);
    chk("w_abort.beats", 64'(n_w), 64'd2);
    areset = 1'b1;
    @(negedge aclk);
    chk("w_abort.outs_rst", 64'(outs()), 64'd0);
    step();
    clear_inputs();
    @(negedge aclk);
    chk("w_abort.outs_next", 64'(outs()), 64'd0);
    step();
    areset = 1'b0;
    @(negedge aclk);
    chk("w_abort.idle", 64'({bus.done, bus.cmd_ready, bus.AWVALID, bus.WVALID}), 64'(4'b0100));
    step();
    run_txn("w_after", 1'b1, 16'h0080, 8'd1, 3'd2, 0, 1'b0, RESP_OKAY, 0);
    chk("w_after.beats", 64'(n_w), 64'd2);
    chk("w_after.flags", 64'({got_err, got_resp}), 64'(3'b000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
